// File: rtl/bowling_ctrl.sv
// bowling_ctrl: throw sequencing controller in front of the bowling scoring datapath.
// Captures one pin count per accepted throw, replays it on N as a train of AD
// strobes (one per pending strike/spare credit plus one), then reads APD back to
// decide between another throw in the frame, a frame change (NF) or game end.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   throw_valid, pins_in one-cycle throw strobe and its pin count (0..10)
//   APD, LF             all-pins-down and last-frame flags from the datapath
//   N, FT               registered pin count and fresh-rack flag
//   AD, NF              add-score and next-frame strobes
//   busy, game_over     controller not idle / game finished (sticky)
//   err                 one-cycle pulse on rejected throw or LF mismatch at game end
module bowling_ctrl #(
   parameter int unsigned FRAMES = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       throw_valid,
   input  logic [3:0] pins_in,
   input  logic       APD,
   input  logic       LF,
   output logic [3:0] N,
   output logic       FT,
   output logic       AD,
   output logic       NF,
   output logic       busy,
   output logic       game_over,
   output logic       err
);

   localparam int unsigned PW = 4;  // pin count width
   localparam int unsigned CW = 2;  // credit / pulse counter width
   localparam int unsigned FW = 4;  // frame counter width
   localparam int unsigned IW = 2;  // throw index width

   typedef enum logic [2:0] {
      ST_WAIT,
      ST_ADD,
      ST_CHK,
      ST_FEND,
      ST_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] n_q, n_d;
   logic [PW-1:0] first_q, first_d;
   logic          ft_q, ft_d;
   logic          ad_q, ad_d;
   logic          nf_q, nf_d;
   logic          busy_q, busy_d;
   logic          over_q, over_d;
   logic          err_q, err_d;
   logic [CW-1:0] cred_next_q, cred_next_d;
   logic [CW-1:0] cred_after_q, cred_after_d;
   logic [CW-1:0] pulse_q, pulse_d;
   logic [FW-1:0] frame_q, frame_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          strike0_q, strike0_d;
   logic          lf_chk_q, lf_chk_d;

   logic last_frame;
   logic strike;
   logic spare;
   logic reject;

   assign last_frame = (frame_q == FW'(FRAMES));
   assign strike     = ft_q & APD;
   assign spare      = ~ft_q & APD;
   // Second throw of a rack may not exceed the pins still standing
   assign reject     = (pins_in > PW'(10)) ||
                       (!ft_q && ((5'(first_q) + 5'(pins_in)) > 5'd10));

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_WAIT;
         n_q          <= '0;
         first_q      <= '0;
         ft_q         <= 1'b1;
         ad_q         <= 1'b0;
         nf_q         <= 1'b0;
         busy_q       <= 1'b0;
         over_q       <= 1'b0;
         err_q        <= 1'b0;
         cred_next_q  <= '0;
         cred_after_q <= '0;
         pulse_q      <= '0;
         frame_q      <= FW'(1);
         idx_q        <= '0;
         strike0_q    <= 1'b0;
         lf_chk_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         n_q          <= n_d;
         first_q      <= first_d;
         ft_q         <= ft_d;
         ad_q         <= ad_d;
         nf_q         <= nf_d;
         busy_q       <= busy_d;
         over_q       <= over_d;
         err_q        <= err_d;
         cred_next_q  <= cred_next_d;
         cred_after_q <= cred_after_d;
         pulse_q      <= pulse_d;
         frame_q      <= frame_d;
         idx_q        <= idx_d;
         strike0_q    <= strike0_d;
         lf_chk_q     <= lf_chk_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d      = state_q;
      n_d          = n_q;
      first_d      = first_q;
      ft_d         = ft_q;
      ad_d         = 1'b0;
      nf_d         = 1'b0;
      over_d       = over_q;
      err_d        = 1'b0;
      cred_next_d  = cred_next_q;
      cred_after_d = cred_after_q;
      pulse_d      = pulse_q;
      frame_d      = frame_q;
      idx_d        = idx_q;
      strike0_d    = strike0_q;
      lf_chk_d     = lf_chk_q;

      unique case (state_q)
         ST_WAIT: begin
            if (throw_valid) begin
               if (reject) begin
                  err_d = 1'b1;
               end else begin
                  n_d = pins_in;
                  if (ft_q) begin
                     first_d = pins_in;
                  end
                  // First pulse starts now; pulse_d holds the extra pulses still owed
                  ad_d    = 1'b1;
                  pulse_d = cred_next_q;
                  state_d = ST_ADD;
               end
            end
         end

         ST_ADD: begin
            // ad_q high: this is a pulse cycle, the low cycle follows by default
            if (!ad_q) begin
               if (pulse_q != '0) begin
                  ad_d    = 1'b1;
                  pulse_d = pulse_q - CW'(1);
               end else begin
                  state_d = ST_CHK;
               end
            end
         end

         ST_CHK: begin
            if (!last_frame) begin
               cred_next_d  = cred_after_q + CW'(strike | spare);
               cred_after_d = CW'(strike);
               if (strike || !ft_q) begin
                  nf_d    = 1'b1;
                  state_d = ST_FEND;
               end else begin
                  ft_d    = 1'b0;
                  idx_d   = idx_q + IW'(1);
                  state_d = ST_WAIT;
               end
            end else begin
               // Final frame consumes credits but never creates new ones
               cred_next_d  = cred_after_q;
               cred_after_d = '0;
               ft_d         = APD;
               if (idx_q == IW'(0)) begin
                  strike0_d = strike;
                  idx_d     = IW'(1);
                  state_d   = ST_WAIT;
               end else if (idx_q == IW'(1) && !strike0_q && !spare) begin
                  nf_d    = 1'b1;
                  state_d = ST_FEND;
               end else if (idx_q == IW'(1)) begin
                  idx_d   = IW'(2);
                  state_d = ST_WAIT;
               end else begin
                  nf_d    = 1'b1;
                  state_d = ST_FEND;
               end
            end
         end

         ST_FEND: begin
            ft_d      = 1'b1;
            idx_d     = '0;
            strike0_d = 1'b0;
            if (last_frame) begin
               over_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               frame_d = frame_q + FW'(1);
               state_d = ST_WAIT;
            end
         end

         ST_DONE: begin
            over_d = 1'b1;
            // Datapath must agree the game ended in its last frame
            if (!lf_chk_q) begin
               lf_chk_d = 1'b1;
               err_d    = ~LF;
            end
         end

         default: begin
            state_d = ST_WAIT;
         end
      endcase

      busy_d = (state_d != ST_WAIT);
   end

   assign N         = n_q;
   assign FT        = ft_q;
   assign AD        = ad_q;
   assign NF        = nf_q;
   assign busy      = busy_q;
   assign game_over = over_q;
   assign err       = err_q;

endmodule

// File: tb/tb_bowling_ctrl.sv
// tb_bowling_ctrl: self-checking bench for bowling_ctrl. A bowling-rules model
// (frame parsing, bonus windows, standard game score) predicts per-throw AD
// counts, FT, APD and NF; the bench also plays the datapath role for APD/LF.
module tb_bowling_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       throw_valid = 1'b0;
   logic [3:0] pins_in = 4'd0;
   logic       APD = 1'b0;
   logic       LF = 1'b0;
   logic [3:0] N;
   logic       FT, AD, NF, busy, game_over, err;

   int n_tests = 0;
   int n_fail  = 0;

   // Monitor-owned counters (only the monitor writes these)
   int ad_cnt = 0, nf_cnt = 0, err_cnt = 0, nsum = 0;
   int n_bad = 0, ft_bad = 0, overlap = 0;
   // Expectations for the throw in flight (written by the stimulus process)
   int cur_n  = 0;
   int cur_ft = 1;

   bowling_ctrl #(.FRAMES(10)) dut (
      .clk        (clk),
      .rst        (rst),
      .throw_valid(throw_valid),
      .pins_in    (pins_in),
      .APD        (APD),
      .LF         (LF),
      .N          (N),
      .FT         (FT),
      .AD         (AD),
      .NF         (NF),
      .busy       (busy),
      .game_over  (game_over),
      .err        (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (AD) begin
         ad_cnt++;
         nsum += int'(N);
         if (int'(N) != cur_n) n_bad++;
         if (int'(FT) != cur_ft) ft_bad++;
      end
      if (NF) nf_cnt++;
      if (err) err_cnt++;
      if (AD && NF) overlap++;
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      throw_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic send(input int p);
      @(negedge clk);
      throw_valid = 1'b1;
      pins_in = 4'(p);
      @(negedge clk);
      throw_valid = 1'b0;
   endtask

   // Wait (bounded) until the controller is idle again or the game is over
   task automatic wait_idle();
      for (int k = 0; k < 200; k++) begin
         if (!busy || game_over) break;
         @(negedge clk);
      end
      check_eq("idle_timeout", int'(busy && !game_over), 0);
      @(negedge clk);
      #1;
   endtask

   // One throw with per-throw expectations
   task automatic throw_chk(input int p, input int ft, input int apd, input int lf,
                            input int mult, input int nf, input string tag);
      int a0, n0, f0, e0, b0, t0;
      cur_n = p; cur_ft = ft;
      APD = apd[0]; LF = lf[0];
      a0 = ad_cnt; n0 = nf_cnt; f0 = ft_bad; e0 = err_cnt; b0 = n_bad; t0 = overlap;
      send(p);
      wait_idle();
      check_eq({tag, "_ad_pulses"}, ad_cnt - a0, mult);
      check_eq({tag, "_n_on_ad"}, n_bad - b0, 0);
      check_eq({tag, "_ft_on_ad"}, ft_bad - f0, 0);
      check_eq({tag, "_nf"}, nf_cnt - n0, nf);
      check_eq({tag, "_err"}, err_cnt - e0, 0);
      check_eq({tag, "_ad_nf_overlap"}, overlap - t0, 0);
   endtask

   function automatic int game_score(input int r[$]);
      int s = 0;
      int i = 0;
      for (int f = 0; f < 10; f++) begin
         if (r[i] == 10) begin
            s += 10 + r[i+1] + r[i+2];
            i += 1;
         end else if (r[i] + r[i+1] == 10) begin
            s += 10 + r[i+2];
            i += 2;
         end else begin
            s += r[i] + r[i+1];
            i += 2;
         end
      end
      return s;
   endfunction

   task automatic gen_game(output int r[$]);
      int a, b, c;
      r = {};
      for (int f = 1; f < 10; f++) begin
         a = int'($urandom_range(10, 0));
         if ($urandom_range(3, 0) == 0) a = 10;
         r.push_back(a);
         if (a != 10) begin
            b = int'($urandom_range(10 - a, 0));
            if ($urandom_range(2, 0) == 0) b = 10 - a;
            r.push_back(b);
         end
      end
      a = ($urandom_range(2, 0) == 0) ? 10 : int'($urandom_range(10, 0));
      r.push_back(a);
      if (a == 10) begin
         b = ($urandom_range(1, 0) == 0) ? 10 : int'($urandom_range(10, 0));
         r.push_back(b);
         c = (b == 10) ? int'($urandom_range(10, 0)) : int'($urandom_range(10 - b, 0));
         r.push_back(c);
      end else begin
         b = ($urandom_range(1, 0) == 0) ? 10 - a : int'($urandom_range(10 - a, 0));
         r.push_back(b);
         if (a + b == 10) begin
            c = int'($urandom_range(10, 0));
            r.push_back(c);
         end
      end
   endtask

   // Play a complete game from reset; model derived from the rules of bowling
   task automatic play_game(input int r[$], input bit lf_ok, input string tag);
      int ft[24], apd[24], fr[24], nf[24], bon[24];
      int i, nt, last, a0, n0, e0, s0;
      for (int k = 0; k < 24; k++) begin
         ft[k] = 0; apd[k] = 0; fr[k] = 0; nf[k] = 0; bon[k] = 0;
      end
      i = 0;
      for (int f = 1; f < 10; f++) begin
         if (r[i] == 10) begin
            ft[i] = 1; apd[i] = 1; nf[i] = 1; fr[i] = f;
            bon[i+1]++; bon[i+2]++;
            i += 1;
         end else begin
            ft[i] = 1; apd[i] = 0; fr[i] = f;
            ft[i+1] = 0; apd[i+1] = int'(r[i] + r[i+1] == 10); nf[i+1] = 1; fr[i+1] = f;
            if (apd[i+1] != 0) bon[i+2]++;
            i += 2;
         end
      end
      ft[i] = 1; apd[i] = int'(r[i] == 10); fr[i] = 10;
      ft[i+1] = apd[i];
      apd[i+1] = (ft[i+1] != 0) ? int'(r[i+1] == 10) : int'(r[i] + r[i+1] == 10);
      fr[i+1] = 10;
      nt = ((apd[i] != 0) || (ft[i+1] == 0 && apd[i+1] != 0)) ? 3 : 2;
      if (nt == 3) begin
         ft[i+2] = apd[i+1];
         apd[i+2] = (ft[i+2] != 0) ? int'(r[i+2] == 10) : int'(r[i+1] + r[i+2] == 10);
         fr[i+2] = 10;
      end
      last = i + nt - 1;
      nf[last] = 1;

      do_reset();
      a0 = ad_cnt; n0 = nf_cnt; e0 = err_cnt; s0 = nsum;
      for (int k = 0; k <= last; k++) begin
         cur_n = r[k]; cur_ft = ft[k];
         APD = apd[k][0]; LF = (fr[k] == 10);
         begin
            int ka0, kn0, kf0, ke0, kb0;
            ka0 = ad_cnt; kn0 = nf_cnt; kf0 = ft_bad; ke0 = err_cnt; kb0 = n_bad;
            send(r[k]);
            if (k == last && !lf_ok) LF = 1'b0;
            wait_idle();
            check_eq($sformatf("%s_t%0d_ad", tag, k), ad_cnt - ka0, 1 + bon[k]);
            check_eq($sformatf("%s_t%0d_n", tag, k), n_bad - kb0, 0);
            check_eq($sformatf("%s_t%0d_ft", tag, k), ft_bad - kf0, 0);
            check_eq($sformatf("%s_t%0d_nf", tag, k), nf_cnt - kn0, nf[k]);
            if (k != last) check_eq($sformatf("%s_t%0d_err", tag, k), err_cnt - ke0, 0);
         end
      end
      repeat (3) @(negedge clk);
      #1;
      check_eq({tag, "_game_over"}, int'(game_over), 1);
      check_eq({tag, "_score"}, nsum - s0, game_score(r));
      check_eq({tag, "_nf_total"}, nf_cnt - n0, 10);
      check_eq({tag, "_lf_err"}, err_cnt - e0, lf_ok ? 0 : 1);
      check_eq({tag, "_overlap"}, overlap, 0);
      // Throws after the game are ignored
      a0 = ad_cnt;
      send(3);
      repeat (4) @(negedge clk);
      #1;
      check_eq({tag, "_done_ignore_ad"}, ad_cnt - a0, 0);
      check_eq({tag, "_done_sticky"}, int'(game_over), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int r[$];
      int e0, a0, seen;

      // Reset values
      @(negedge clk);
      @(negedge clk);
      check_eq("rst_N", int'(N), 0);
      check_eq("rst_FT", int'(FT), 1);
      check_eq("rst_AD", int'(AD), 0);
      check_eq("rst_NF", int'(NF), 0);
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_game_over", int'(game_over), 0);
      check_eq("rst_err", int'(err), 0);
      rst = 1'b0;

      // Rejections and dropped throw while busy
      e0 = err_cnt;
      send(11);
      @(negedge clk); #1;
      check_eq("rej11_err", err_cnt - e0, 1);
      check_eq("rej11_N", int'(N), 0);
      check_eq("rej11_busy", int'(busy), 0);
      check_eq("rej11_FT", int'(FT), 1);
      cur_n = 5; cur_ft = 1; APD = 1'b0; LF = 1'b0;
      a0 = ad_cnt; e0 = err_cnt;
      send(5);
      throw_valid = 1'b1; pins_in = 4'd2;
      @(negedge clk);
      throw_valid = 1'b0;
      wait_idle();
      check_eq("busy_drop_ad", ad_cnt - a0, 1);
      check_eq("busy_drop_err", err_cnt - e0, 0);
      check_eq("busy_drop_N", int'(N), 5);
      check_eq("busy_drop_FT", int'(FT), 0);
      e0 = err_cnt;
      send(6);
      @(negedge clk); #1;
      check_eq("rej6_err", err_cnt - e0, 1);
      check_eq("rej6_N", int'(N), 5);
      check_eq("rej6_FT", int'(FT), 0);
      check_eq("rej6_busy", int'(busy), 0);
      throw_chk(5, 0, 1, 0, 1, 1, "spare5");

      // Reset in the middle of a 3-pulse train
      do_reset();
      throw_chk(10, 1, 1, 0, 1, 1, "rt_s1");
      throw_chk(10, 1, 1, 0, 2, 1, "rt_s2");
      cur_n = 10; cur_ft = 1; APD = 1'b1;
      send(10);
      seen = 1;
      for (int k = 0; k < 20; k++) begin
         if (seen == 2) break;
         @(negedge clk);
         if (AD) seen++;
      end
      check_eq("rt_second_pulse", seen, 2);
      rst = 1'b1;
      @(negedge clk);
      check_eq("rt_AD", int'(AD), 0);
      check_eq("rt_N", int'(N), 0);
      check_eq("rt_FT", int'(FT), 1);
      check_eq("rt_busy", int'(busy), 0);
      check_eq("rt_NF", int'(NF), 0);
      check_eq("rt_game_over", int'(game_over), 0);
      rst = 1'b0;
      throw_chk(3, 1, 0, 0, 1, 0, "rt_after");

      // Directed games
      r = {};
      for (int k = 0; k < 20; k++) r.push_back(4);
      play_game(r, 1'b1, "fours");
      r = {};
      for (int k = 0; k < 12; k++) r.push_back(10);
      play_game(r, 1'b1, "perfect");
      r = {};
      for (int k = 0; k < 18; k++) r.push_back(1);
      r.push_back(7); r.push_back(3); r.push_back(5);
      play_game(r, 1'b1, "fill735");
      r = {10, 3, 4};
      for (int k = 0; k < 16; k++) r.push_back(0);
      play_game(r, 1'b1, "strike34");

      // Random games, one with the datapath disagreeing on LF
      for (int g = 0; g < 8; g++) begin
         gen_game(r);
         play_game(r, (g != 3), $sformatf("rnd%0d", g));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
